// File: rtl/inst_sequencer_pkg.sv
// Shared types, field positions and class rules for the instruction sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package inst_sequencer_pkg;

    // Encodings are visible on the debug state port and must stay fixed.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH0 = 4'd1,
        S_FETCH1 = 4'd2,
        S_FETCH2 = 4'd3,
        S_ISSUE  = 4'd4,
        S_ERR    = 4'd15
    } seq_state_t;

    localparam int ALU_OP_W = 6;
    localparam int FIELD_W  = 4;

    // Word0 field positions
    localparam int CLS_LSB  = 12;
    localparam int DEST_LSB = 8;
    localparam int S1_LSB   = 4;
    localparam int S2_LSB   = 0;

    // Class boundaries and memory classes
    localparam logic [3:0] CLS_IMM_BASE = 4'h8;  // first two-word class
    localparam logic [3:0] CLS_EXT_BASE = 4'hC;  // first three-word class
    localparam logic [3:0] CLS_RD_IMM   = 4'hA;
    localparam logic [3:0] CLS_WR_IMM   = 4'hB;
    localparam logic [3:0] CLS_RD_EXT   = 4'hD;
    localparam logic [3:0] CLS_WR_EXT   = 4'hE;
    localparam logic [3:0] CLS_ILLEGAL  = 4'hF;

    // Upper two bits of alu_op for the classes that carry the op in the class field
    localparam logic [1:0] ALU_GRP_REG = 2'b00;
    localparam logic [1:0] ALU_GRP_IMM = 2'b01;

    // Instruction length in words; 0 marks the illegal class.
    function automatic logic [1:0] class_words(input logic [3:0] cls);
        if (cls == CLS_ILLEGAL) begin
            return 2'd0;
        end else if (cls >= CLS_EXT_BASE) begin
            return 2'd3;
        end else if (cls >= CLS_IMM_BASE) begin
            return 2'd2;
        end
        return 2'd1;
    endfunction

    function automatic logic class_mem_rd(input logic [3:0] cls);
        return (cls == CLS_RD_IMM) || (cls == CLS_RD_EXT);
    endfunction

    function automatic logic class_mem_wr(input logic [3:0] cls);
        return (cls == CLS_WR_IMM) || (cls == CLS_WR_EXT);
    endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Fetch, flush, micro-op and debug signals between the sequencer and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: fetch and micro-op sides are independent valid/ready pairs.
interface inst_sequencer_if
    import inst_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic                i_flush;
    logic [DATA_W-1:0]   i_fetch_data;
    logic                i_fetch_valid;
    logic                o_fetch_ready;
    logic                o_uop_valid;
    logic                i_uop_ready;
    logic [ALU_OP_W-1:0] o_alu_op;
    logic [REG_AW-1:0]   o_s1;
    logic [REG_AW-1:0]   o_s2;
    logic [REG_AW-1:0]   o_dest;
    logic                o_mem_rd;
    logic                o_mem_wr;
    logic [DATA_W-1:0]   o_imm;
    logic [3:0]          o_state;
    logic                o_err;

    // Environment side: fetch unit, execute stage and flush source.
    modport master (
        output i_flush, i_fetch_data, i_fetch_valid, i_uop_ready,
        input  o_fetch_ready, o_uop_valid, o_alu_op, o_s1, o_s2, o_dest,
               o_mem_rd, o_mem_wr, o_imm, o_state, o_err
    );

    // Sequencer side.
    modport slave (
        input  i_flush, i_fetch_data, i_fetch_valid, i_uop_ready,
        output o_fetch_ready, o_uop_valid, o_alu_op, o_s1, o_s2, o_dest,
               o_mem_rd, o_mem_wr, o_imm, o_state, o_err
    );

endinterface

// File: rtl/inst_sequencer_field_decode.sv
// Splits instruction word0 into class/register fields and length, and flags illegal encodings.
// Latency: combinational.
// Backpressure: none.
module inst_sequencer_field_decode
    import inst_sequencer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 3,
    parameter int REG_AW    = 4
)(
    input  logic [DATA_W-1:0] word0,
    output logic [3:0]        cls,
    output logic [REG_AW-1:0] dest,
    output logic [REG_AW-1:0] s1,
    output logic [REG_AW-1:0] s2,
    output logic [1:0]        nwords,
    output logic              illegal
);

    logic rsvd_nz;

    // Bits above the 16-bit encoding only exist for wider words and must be zero.
    generate
        if (DATA_W > 16) begin : g_rsvd
            assign rsvd_nz = |word0[DATA_W-1:16];
        end else begin : g_no_rsvd
            assign rsvd_nz = 1'b0;
        end
    endgenerate

    // Field extraction, length lookup and legality for the configured maximum length.
    always_comb begin
        cls     = word0[CLS_LSB +: FIELD_W];
        dest    = REG_AW'(word0[DEST_LSB +: FIELD_W]);
        s1      = REG_AW'(word0[S1_LSB +: FIELD_W]);
        s2      = REG_AW'(word0[S2_LSB +: FIELD_W]);
        nwords  = class_words(cls);
        illegal = (nwords == 2'd0) || (int'(nwords) > MAX_WORDS) || rsvd_nz;
    end

endmodule

// File: rtl/inst_sequencer.sv
// Fetches 1..MAX_WORDS instruction words and issues one registered micro-op per instruction.
// Latency: last word accepted at cycle N gives uop_valid at N+1; 1-word instrs stream one per cycle.
// Backpressure: micro-op held stable until ready; fetch only accepted when the issue slot frees.
module inst_sequencer
    import inst_sequencer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 3,
    parameter int REG_AW    = 4
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    inst_sequencer_if.slave  bus
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic       err_q;

    // Partially fetched instruction
    logic [3:0]          cls_q;
    logic [REG_AW-1:0]   dest_q;
    logic [REG_AW-1:0]   s1_q;
    logic [REG_AW-1:0]   s2_q;
    logic [1:0]          nwords_q;
    logic [ALU_OP_W-1:0] ext_op_q;

    // Registered micro-op
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [REG_AW-1:0]   uop_dest_q;
    logic [REG_AW-1:0]   uop_s1_q;
    logic [REG_AW-1:0]   uop_s2_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [DATA_W-1:0]   imm_q;

    // Decoder outputs for the word currently on the fetch port
    logic [3:0]          dec_cls;
    logic [REG_AW-1:0]   dec_dest;
    logic [REG_AW-1:0]   dec_s1;
    logic [REG_AW-1:0]   dec_s2;
    logic [1:0]          dec_nwords;
    logic                dec_illegal;

    // Control
    logic                fetch_ready;
    logic                uop_valid;
    logic                take0;
    logic                take1;
    logic                take2;
    logic                err_set;

    // Next micro-op
    logic                out_load;
    logic [ALU_OP_W-1:0] alu_op_d;
    logic [REG_AW-1:0]   uop_dest_d;
    logic [REG_AW-1:0]   uop_s1_d;
    logic [REG_AW-1:0]   uop_s2_d;
    logic                mem_rd_d;
    logic                mem_wr_d;
    logic [DATA_W-1:0]   imm_d;

    inst_sequencer_field_decode #(
        .DATA_W    (DATA_W),
        .MAX_WORDS (MAX_WORDS),
        .REG_AW    (REG_AW)
    ) u_decode (
        .word0   (bus.i_fetch_data),
        .cls     (dec_cls),
        .dest    (dec_dest),
        .s1      (dec_s1),
        .s2      (dec_s2),
        .nwords  (dec_nwords),
        .illegal (dec_illegal)
    );

    // Next state, handshake outputs and word-accept strobes; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        fetch_ready = 1'b0;
        uop_valid   = 1'b0;
        take0       = 1'b0;
        take1       = 1'b0;
        take2       = 1'b0;
        err_set     = 1'b0;

        if (bus.i_flush) begin
            state_d = S_FETCH0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH0;
                end
                S_FETCH0: begin
                    fetch_ready = 1'b1;
                    take0       = bus.i_fetch_valid;
                end
                S_FETCH1: begin
                    fetch_ready = 1'b1;
                    take1       = bus.i_fetch_valid;
                    if (bus.i_fetch_valid) begin
                        state_d = (nwords_q == 2'd2) ? S_ISSUE : S_FETCH2;
                    end
                end
                S_FETCH2: begin
                    fetch_ready = 1'b1;
                    take2       = bus.i_fetch_valid;
                    if (bus.i_fetch_valid) begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A new word0 may only enter once the pending micro-op leaves.
                    uop_valid   = 1'b1;
                    fetch_ready = bus.i_uop_ready;
                    if (bus.i_uop_ready) begin
                        take0 = bus.i_fetch_valid;
                        if (!bus.i_fetch_valid) begin
                            state_d = S_FETCH0;
                        end
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (take0) begin
                if (dec_illegal) begin
                    state_d = S_ERR;
                    err_set = 1'b1;
                end else if (dec_nwords == 2'd1) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FETCH1;
                end
            end
        end
    end

    // Assemble the micro-op on the cycle its last word is accepted.
    always_comb begin
        out_load   = 1'b0;
        alu_op_d   = '0;
        uop_dest_d = dest_q;
        uop_s1_d   = s1_q;
        uop_s2_d   = s2_q;
        mem_rd_d   = class_mem_rd(cls_q);
        mem_wr_d   = class_mem_wr(cls_q);
        imm_d      = '0;

        if (take0 && !dec_illegal && (dec_nwords == 2'd1)) begin
            out_load   = 1'b1;
            alu_op_d   = {ALU_GRP_REG, dec_cls};
            uop_dest_d = dec_dest;
            uop_s1_d   = dec_s1;
            uop_s2_d   = dec_s2;
            mem_rd_d   = class_mem_rd(dec_cls);
            mem_wr_d   = class_mem_wr(dec_cls);
            imm_d      = '0;
        end else if (take1 && (nwords_q == 2'd2)) begin
            out_load = 1'b1;
            alu_op_d = {ALU_GRP_IMM, cls_q};
            imm_d    = bus.i_fetch_data;
        end else if (take2) begin
            out_load = 1'b1;
            alu_op_d = ext_op_q;
            imm_d    = bus.i_fetch_data;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-instruction flag, cleared only by flush or reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (bus.i_flush) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    // Holds word0 fields and the word1 op until the instruction completes; flush discards them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            cls_q    <= '0;
            dest_q   <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            nwords_q <= '0;
            ext_op_q <= '0;
        end else begin
            if (take0) begin
                cls_q    <= dec_cls;
                dest_q   <= dec_dest;
                s1_q     <= dec_s1;
                s2_q     <= dec_s2;
                nwords_q <= dec_nwords;
            end
            if (take1) begin
                ext_op_q <= bus.i_fetch_data[ALU_OP_W-1:0];
            end
        end
    end

    // Registered micro-op; only reloads when the issue slot is free, so it stays stable under stall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            alu_op_q   <= '0;
            uop_dest_q <= '0;
            uop_s1_q   <= '0;
            uop_s2_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            imm_q      <= '0;
        end else if (out_load) begin
            alu_op_q   <= alu_op_d;
            uop_dest_q <= uop_dest_d;
            uop_s1_q   <= uop_s1_d;
            uop_s2_q   <= uop_s2_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            imm_q      <= imm_d;
        end
    end

    assign bus.o_fetch_ready = fetch_ready;
    assign bus.o_uop_valid   = uop_valid;
    assign bus.o_alu_op      = alu_op_q;
    assign bus.o_dest        = uop_dest_q;
    assign bus.o_s1          = uop_s1_q;
    assign bus.o_s2          = uop_s2_q;
    assign bus.o_mem_rd      = mem_rd_q;
    assign bus.o_mem_wr      = mem_wr_q;
    assign bus.o_imm         = imm_q;
    assign bus.o_state       = state_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: directed scenarios plus randomized streams vs a reference model.
// Latency: n/a.
// Backpressure: bench drives random fetch_valid and uop_ready patterns.
module tb_inst_sequencer;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        rd;
        logic        wr;
        logic [15:0] imm;
    } uop_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] word_q[$];
    uop_t        got_q[$];

    inst_sequencer_if #(.DATA_W(16), .REG_AW(4)) bus3 ();
    inst_sequencer_if #(.DATA_W(16), .REG_AW(4)) bus2 ();

    inst_sequencer #(.DATA_W(16), .MAX_WORDS(3), .REG_AW(4)) dut3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus3.slave)
    );

    inst_sequencer #(.DATA_W(16), .MAX_WORDS(2), .REG_AW(4)) dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int instr_len(input logic [15:0] w0);
        int c;
        c = int'(w0[15:12]);
        if (c < 8)  return 1;
        if (c < 12) return 2;
        if (c < 15) return 3;
        return 0;
    endfunction

    function automatic uop_t model_uop(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        uop_t u;
        int   c;
        int   len;
        c      = int'(w0[15:12]);
        len    = instr_len(w0);
        u.dest = w0[11:8];
        u.s1   = w0[7:4];
        u.s2   = w0[3:0];
        if (len == 1) begin
            u.alu_op = 6'(c);
            u.imm    = 16'h0;
        end else if (len == 2) begin
            u.alu_op = 6'(16 + c);
            u.imm    = w1;
        end else begin
            u.alu_op = w1[5:0];
            u.imm    = w2;
        end
        u.rd = (c == 10) || (c == 13);
        u.wr = (c == 11) || (c == 14);
        return u;
    endfunction

    function automatic uop_t read_uop3();
        uop_t u;
        u.alu_op = bus3.o_alu_op;
        u.dest   = bus3.o_dest;
        u.s1     = bus3.o_s1;
        u.s2     = bus3.o_s2;
        u.rd     = bus3.o_mem_rd;
        u.wr     = bus3.o_mem_wr;
        u.imm    = bus3.o_imm;
        return u;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one word on dut3 until it is accepted; returns at the following negedge.
    task automatic put_word3(input logic [15:0] w);
        int n;
        n = 0;
        bus3.i_fetch_valid = 1'b1;
        bus3.i_fetch_data  = w;
        #1;
        while (!bus3.o_fetch_ready && n < 50) begin
            step();
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL put_word3 accept timeout: word=%h ready=%b required=1", w, bus3.o_fetch_ready);
        end
        step();
        bus3.i_fetch_valid = 1'b0;
    endtask

    task automatic drain_uop3();
        bus3.i_uop_ready = 1'b1;
        step();
        bus3.i_uop_ready = 1'b0;
    endtask

    // Streams word_q into dut3 with random handshakes, collecting issued uops in got_q.
    task automatic run_stream(input int vld_pct, input int rdy_pct, input int n_uops, output int used);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        got_q.delete();
        while (got_q.size() < n_uops && cyc < 20000) begin
            bus3.i_fetch_valid = (idx < word_q.size()) && ($urandom_range(99) < vld_pct);
            bus3.i_fetch_data  = (idx < word_q.size()) ? word_q[idx] : 16'($urandom);
            bus3.i_uop_ready   = ($urandom_range(99) < rdy_pct);
            #1;
            if (bus3.i_fetch_valid && bus3.o_fetch_ready) idx++;
            if (bus3.o_uop_valid && bus3.i_uop_ready) got_q.push_back(read_uop3());
            step();
            cyc++;
        end
        bus3.i_fetch_valid = 1'b0;
        bus3.i_uop_ready   = 1'b0;
        used = idx;
        checks++;
        if (cyc >= 20000) begin
            failures++;
            $display("FAIL stream timeout: uops=%0d required=%0d", got_q.size(), n_uops);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus3.i_flush = 0; bus3.i_fetch_valid = 0; bus3.i_fetch_data = 0; bus3.i_uop_ready = 0;
        bus2.i_flush = 0; bus2.i_fetch_valid = 0; bus2.i_fetch_data = 0; bus2.i_uop_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus3.o_state, bus3.o_fetch_ready, bus3.o_uop_valid, bus3.o_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset ctrl: state=%h rdy=%b vld=%b err=%b required all 0",
                     bus3.o_state, bus3.o_fetch_ready, bus3.o_uop_valid, bus3.o_err);
        end
        checks++;
        if (read_uop3() !== uop_t'(0)) begin
            failures++;
            $display("FAIL reset uop fields: got=%h required=0", read_uop3());
        end
        checks++;
        if ({bus2.o_state, bus2.o_err, bus2.o_uop_valid} !== 6'b0) begin
            failures++;
            $display("FAIL reset dut2: state=%h err=%b vld=%b required 0", bus2.o_state, bus2.o_err, bus2.o_uop_valid);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus3.o_state !== 4'd1 || bus3.o_fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL post-reset fetch0: state=%h rdy=%b required 1/1", bus3.o_state, bus3.o_fetch_ready);
        end
    endtask

    task automatic test_one_word();
        uop_t exp;
        exp = '{alu_op: 6'h02, dest: 4'd1, s1: 4'd0, s2: 4'd5, rd: 1'b0, wr: 1'b0, imm: 16'h0};
        bus3.i_uop_ready = 1'b0;
        put_word3(16'h2105);
        checks++;
        if (bus3.o_uop_valid !== 1'b1) begin
            failures++;
            $display("FAIL one_word latency: uop_valid=%b required=1", bus3.o_uop_valid);
        end
        checks++;
        if (read_uop3() !== exp) begin
            failures++;
            $display("FAIL one_word uop: got=%h required=%h", read_uop3(), exp);
        end
        drain_uop3();
        checks++;
        if (bus3.o_uop_valid !== 1'b0 || bus3.o_state !== 4'd1) begin
            failures++;
            $display("FAIL one_word drain: vld=%b state=%h required 0/1", bus3.o_uop_valid, bus3.o_state);
        end
    endtask

    task automatic test_two_word();
        uop_t exp;
        exp = '{alu_op: 6'h1A, dest: 4'd1, s1: 4'd2, s2: 4'd3, rd: 1'b1, wr: 1'b0, imm: 16'h0040};
        put_word3(16'hA123);
        checks++;
        if (bus3.o_uop_valid !== 1'b0 || bus3.o_state !== 4'd2) begin
            failures++;
            $display("FAIL two_word mid: vld=%b state=%h required 0/2", bus3.o_uop_valid, bus3.o_state);
        end
        put_word3(16'h0040);
        checks++;
        if (bus3.o_uop_valid !== 1'b1 || read_uop3() !== exp) begin
            failures++;
            $display("FAIL two_word uop: vld=%b got=%h required=%h", bus3.o_uop_valid, read_uop3(), exp);
        end
        drain_uop3();
    endtask

    task automatic test_three_word();
        uop_t exp;
        exp = '{alu_op: 6'h23, dest: 4'd4, s1: 4'd5, s2: 4'd6, rd: 1'b0, wr: 1'b0, imm: 16'hBEEF};
        put_word3(16'hC456);
        put_word3(16'h0023);
        checks++;
        if (bus3.o_state !== 4'd3 || bus3.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL three_word mid: state=%h vld=%b required 3/0", bus3.o_state, bus3.o_uop_valid);
        end
        put_word3(16'hBEEF);
        checks++;
        if (bus3.o_uop_valid !== 1'b1 || read_uop3() !== exp) begin
            failures++;
            $display("FAIL three_word uop: vld=%b got=%h required=%h", bus3.o_uop_valid, read_uop3(), exp);
        end
        drain_uop3();
    endtask

    task automatic test_max_words2();
        bus2.i_fetch_valid = 1'b1;
        bus2.i_fetch_data  = 16'hC456;
        #1;
        checks++;
        if (bus2.o_fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL max2 ready: rdy=%b required=1", bus2.o_fetch_ready);
        end
        step();
        bus2.i_fetch_valid = 1'b0;
        checks++;
        if (bus2.o_err !== 1'b1 || bus2.o_state !== 4'hF || bus2.o_fetch_ready !== 1'b0 || bus2.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL max2 err: err=%b state=%h rdy=%b vld=%b required 1/f/0/0",
                     bus2.o_err, bus2.o_state, bus2.o_fetch_ready, bus2.o_uop_valid);
        end
        bus2.i_flush = 1'b1;
        step();
        bus2.i_flush = 1'b0;
        // Two-word instructions stay legal on the shorter configuration.
        for (int k = 0; k < 2; k++) begin
            bus2.i_fetch_valid = 1'b1;
            bus2.i_fetch_data  = (k == 0) ? 16'hB9AB : 16'h1234;
            step();
        end
        bus2.i_fetch_valid = 1'b0;
        checks++;
        if (bus2.o_uop_valid !== 1'b1 || bus2.o_err !== 1'b0 || bus2.o_alu_op !== 6'h1B ||
            bus2.o_mem_wr !== 1'b1 || bus2.o_mem_rd !== 1'b0 || bus2.o_imm !== 16'h1234 || bus2.o_dest !== 4'd9) begin
            failures++;
            $display("FAIL max2 two_word: vld=%b err=%b op=%h wr=%b rd=%b imm=%h dest=%h required 1/0/1b/1/0/1234/9",
                     bus2.o_uop_valid, bus2.o_err, bus2.o_alu_op, bus2.o_mem_wr, bus2.o_mem_rd, bus2.o_imm, bus2.o_dest);
        end
    endtask

    task automatic test_illegal_flush();
        put_word3(16'hF000);
        checks++;
        if (bus3.o_err !== 1'b1 || bus3.o_state !== 4'hF || bus3.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal err: err=%b state=%h vld=%b required 1/f/0", bus3.o_err, bus3.o_state, bus3.o_uop_valid);
        end
        bus3.i_fetch_valid = 1'b1;
        bus3.i_fetch_data  = 16'h1111;
        bus3.i_uop_ready   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus3.o_fetch_ready !== 1'b0 || bus3.o_err !== 1'b1) begin
                failures++;
                $display("FAIL illegal hold cycle %0d: rdy=%b err=%b required 0/1", c, bus3.o_fetch_ready, bus3.o_err);
            end
            step();
        end
        bus3.i_flush = 1'b1;
        #1;
        checks++;
        if (bus3.o_fetch_ready !== 1'b0 || bus3.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL illegal flush cycle: rdy=%b vld=%b required 0/0", bus3.o_fetch_ready, bus3.o_uop_valid);
        end
        step();
        bus3.i_flush       = 1'b0;
        bus3.i_fetch_valid = 1'b0;
        bus3.i_uop_ready   = 1'b0;
        checks++;
        if (bus3.o_err !== 1'b0 || bus3.o_state !== 4'd1) begin
            failures++;
            $display("FAIL illegal after flush: err=%b state=%h required 0/1", bus3.o_err, bus3.o_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [4];
        uop_t        exp;
        seq[0] = 16'h1234; seq[1] = 16'h3456; seq[2] = 16'h0789; seq[3] = 16'h7ABC;
        bus3.i_uop_ready = 1'b0;
        put_word3(seq[0]);
        exp = model_uop(seq[0], 16'h0, 16'h0);
        // Stalled issue: a waiting fetch word must not be taken and the uop must not move.
        bus3.i_fetch_valid = 1'b1;
        bus3.i_fetch_data  = seq[1];
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus3.o_uop_valid !== 1'b1 || read_uop3() !== exp || bus3.o_fetch_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall cycle %0d: vld=%b rdy=%b got=%h required=%h",
                         c, bus3.o_uop_valid, bus3.o_fetch_ready, read_uop3(), exp);
            end
            step();
        end
        for (int k = 0; k < 4; k++) begin
            bus3.i_uop_ready   = 1'b1;
            bus3.i_fetch_valid = (k < 3);
            bus3.i_fetch_data  = seq[(k + 1) % 4];
            #1;
            exp = model_uop(seq[k], 16'h0, 16'h0);
            checks++;
            if (bus3.o_uop_valid !== 1'b1 || read_uop3() !== exp) begin
                failures++;
                $display("FAIL back_to_back %0d: vld=%b got=%h required=%h", k, bus3.o_uop_valid, read_uop3(), exp);
            end
            step();
        end
        bus3.i_uop_ready   = 1'b0;
        bus3.i_fetch_valid = 1'b0;
        checks++;
        if (bus3.o_uop_valid !== 1'b0 || bus3.o_state !== 4'd1) begin
            failures++;
            $display("FAIL back_to_back end: vld=%b state=%h required 0/1", bus3.o_uop_valid, bus3.o_state);
        end
    endtask

    task automatic test_flush_mid_instr();
        uop_t exp;
        exp = '{alu_op: 6'h03, dest: 4'd7, s1: 4'd0, s2: 4'd0, rd: 1'b0, wr: 1'b0, imm: 16'h0};
        put_word3(16'hC111);
        put_word3(16'h0015);
        bus3.i_flush       = 1'b1;
        bus3.i_fetch_valid = 1'b1;
        bus3.i_fetch_data  = 16'h3700;
        bus3.i_uop_ready   = 1'b1;
        #1;
        checks++;
        if (bus3.o_fetch_ready !== 1'b0 || bus3.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_mid cycle: rdy=%b vld=%b required 0/0", bus3.o_fetch_ready, bus3.o_uop_valid);
        end
        step();
        bus3.i_flush     = 1'b0;
        bus3.i_uop_ready = 1'b0;
        checks++;
        if (bus3.o_state !== 4'd1 || bus3.o_uop_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_mid after: state=%h vld=%b required 1/0", bus3.o_state, bus3.o_uop_valid);
        end
        put_word3(16'h3700);
        checks++;
        if (bus3.o_uop_valid !== 1'b1 || read_uop3() !== exp || bus3.o_err !== 1'b0) begin
            failures++;
            $display("FAIL flush_mid next instr: vld=%b err=%b got=%h required=%h",
                     bus3.o_uop_valid, bus3.o_err, read_uop3(), exp);
        end
        drain_uop3();
    endtask

    task automatic test_random(input int n, input int vld_pct, input int rdy_pct);
        uop_t        exp_q[$];
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          len;
        int          used;
        word_q.delete();
        for (int i = 0; i < n; i++) begin
            w0  = {4'($urandom_range(14)), 12'($urandom)};
            w1  = 16'($urandom);
            w2  = 16'($urandom);
            len = instr_len(w0);
            word_q.push_back(w0);
            if (len >= 2) word_q.push_back(w1);
            if (len >= 3) word_q.push_back(w2);
            exp_q.push_back(model_uop(w0, w1, w2));
        end
        run_stream(vld_pct, rdy_pct, n, used);
        checks++;
        if (got_q.size() != n) begin
            failures++;
            $display("FAIL random count: uops=%0d required=%0d", got_q.size(), n);
        end
        checks++;
        if (used != word_q.size()) begin
            failures++;
            $display("FAIL random words consumed: got=%0d required=%0d", used, word_q.size());
        end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random uop %0d: got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_one_word();
        test_two_word();
        test_three_word();
        test_max_words2();
        test_illegal_flush();
        test_back_to_back();
        test_flush_mid_instr();
        test_random(40, 70, 70);
        test_random(40, 40, 30);
        test_random(30, 100, 100);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
